avmm_mem_responder: RTL and testbench
=====================================

Name: avmm_mem_responder

Overview:
Avalon-MM memory slave that serves the matrix/vector fetch path. It responds to the data fetcher's 64-bit word reads with programmable waitrequest stalls, a fixed pipelined read latency and a bounded number of outstanding reads. It also accepts byte-masked writes so benches and host logic can load operands. It holds matrix A in words 0..7 and vector B in word 8.

Parameters:
ADDR_W, 32, address width; the address is a word index.
DATA_W, 64, data width; fixed at 8 bytes.
DEPTH, 16, number of words; must be a power of 2.
WAIT_CYCLES, 2, waitrequest stall cycles before each command is accepted (0 = accept immediately).
RD_LATENCY, 3, cycles from the read-accept edge to readdatavalid (valid range 1..8).
MAX_OUTSTANDING, 4, maximum number of reads accepted but not yet returned.

Ports:
clk, input, 1, clock; rising edge.
rst, input, 1, asynchronous active-high reset.
address, input, ADDR_W, word address.
read, input, 1, read command.
write, input, 1, write command.
writedata, input, DATA_W, write data.
byteenable, input, DATA_W/8, write byte mask; bit j enables byte j.
readdata, output, DATA_W, read response data.
readdatavalid, output, 1, one-cycle pulse per read response.
waitrequest, output, 1, command stall.
err, output, 1, one-cycle pulse on an illegal accepted command.

Behaviour:
- Reset (rst high, asynchronous):
  - readdata=0, readdatavalid=0, err=0.
  - Read pipeline flushed, outstanding count=0, stall counter=0.
  - Memory reinitialised: byte j of word i = (i*16+j) mod 256, so word 0 = 64'h0706050403020100.
  - waitrequest is forced to 1 while rst is high.
- waitrequest (combinational) = cmd && (stall_cnt != WAIT_CYCLES || (read && outstanding == MAX_OUTSTANDING)), where cmd = read|write.
- stall_cnt:
  - Increments on each edge where cmd is high and waitrequest is high, saturating at WAIT_CYCLES.
  - Clears to 0 on each accept edge.
  - Clears when cmd drops without an accept.
- Accept edge: a rising edge with cmd=1 and waitrequest=0. The master holds address and data stable until accept. At WAIT_CYCLES=0 with a non-full pipeline, a command asserted every cycle is accepted every cycle.
- Write:
  - At the accept edge, each byte with byteenable[j]=1 is written.
  - No response is generated.
- Read:
  - Data is sampled at the accept edge. A write accepted on an earlier edge is visible; read and write commands are accepted one per edge.
  - The sampled data enters a RD_LATENCY-stage pipeline.
  - readdatavalid is high, with readdata, during the cycle RD_LATENCY edges after accept.
  - Responses return in order; one read produces exactly one valid pulse.
  - readdata holds its last value when readdatavalid=0.
- Outstanding count:
  - +1 on read accept, -1 on a readdatavalid edge, unchanged when both occur on the same edge.
  - Never exceeds MAX_OUTSTANDING.
- Out of range (address >= DEPTH):
  - Read returns 64'hDEADBEEFDEADBEEF with normal latency.
  - Write is dropped.
  - err pulses the cycle after accept.
- read and write both high: treated as a read only, the write is dropped, and err pulses the cycle after accept.
- Reset mid-operation: pending responses are discarded. No readdatavalid pulse is issued for pre-reset reads after rst is released.

Test Plan:
- Reset, WAIT=2, LAT=3, hold read address 0 -> waitrequest high for 2 edges, accepted on the 3rd; readdatavalid exactly 3 edges later; readdata=64'h0706050403020100.
- Fetch sequence reads words 0..8, each held until accept -> 9 in-order valid pulses; word 8 = 64'h8786858483828180; err never asserts.
- Write word 3 with writedata=64'hFFFFFFFFFFFFFFFF and byteenable=8'h0F, then read word 3 -> readdata=64'h37363534FFFFFFFF.
- WAIT=0, LAT=6, MAX=4, read held high continuously:
  - 4 accepts on consecutive edges, then waitrequest=1 until the first valid edge.
  - Thereafter at most one accept per valid; count never exceeds 4.
- Read address 16 -> readdata=64'hDEADBEEFDEADBEEF after LAT; err one pulse. Write address 20 -> memory unchanged; err one pulse.
- Two reads outstanding, then pulse rst for 1 cycle -> readdatavalid=0 immediately and no valids after release; a subsequent read of word 3 returns 64'h3736353433323130.

Source files
------------

// File: rtl/avmm_mem_responder.sv
// Avalon-MM 64-bit memory slave with programmable waitrequest stalls, fixed pipelined
// read latency, bounded outstanding reads and byte-masked writes.
module avmm_mem_responder #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned WAIT_CYCLES     = 2,
    parameter int unsigned RD_LATENCY      = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned OC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DATA_W-1:0] OOR_DATA = {(DATA_W / 32){32'hDEADBEEF}};

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [SC_W-1:0]       r_stall;
    logic [OC_W-1:0]       r_outst;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [DATA_W-1:0]     r_dpipe [RD_LATENCY];
    logic                  r_err;

    logic                  w_cmd;
    logic                  w_stall_done;
    logic                  w_full;
    logic                  w_wait;
    logic                  w_accept;
    logic                  w_acc_rd;
    logic                  w_acc_wr;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_W-1:0]     w_rd_data;
    logic [SC_W-1:0]       w_stall_d;
    logic [OC_W-1:0]       w_outst_d;

    assign w_cmd        = read | write;
    assign w_stall_done = (r_stall == SC_W'(WAIT_CYCLES));
    assign w_full       = (r_outst == OC_W'(MAX_OUTSTANDING));
    assign w_wait       = w_cmd & (~w_stall_done | (read & w_full));
    assign waitrequest  = rst | w_wait;

    assign w_accept  = w_cmd & ~w_wait;
    assign w_acc_rd  = w_accept & read;
    assign w_oor     = (address >= ADDR_W'(DEPTH));
    // A simultaneous read+write is served as a read; the write half is dropped.
    assign w_acc_wr  = w_accept & write & ~read & ~w_oor;
    assign w_idx     = address[IDX_W-1:0];
    assign w_rd_data = w_oor ? OOR_DATA : r_mem[w_idx];

    assign readdata      = r_dpipe[RD_LATENCY-1];
    assign readdatavalid = r_vpipe[RD_LATENCY-1];
    assign err           = r_err;

    always_comb begin
        w_stall_d = r_stall;
        if (w_accept || !w_cmd) begin
            w_stall_d = '0;
        end else if (!w_stall_done) begin
            w_stall_d = r_stall + SC_W'(1);
        end
    end

    always_comb begin
        w_outst_d = r_outst;
        if (w_acc_rd && !readdatavalid) begin
            w_outst_d = r_outst + OC_W'(1);
        end else if (!w_acc_rd && readdatavalid) begin
            w_outst_d = r_outst - OC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_outst <= '0;
            r_err   <= 1'b0;
            r_vpipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_dpipe[k] <= '0;
            end
        end else begin
            r_stall <= w_stall_d;
            r_outst <= w_outst_d;
            r_err   <= w_accept & (w_oor | (read & write));
            // Data registers only load with a valid beat so readdata holds between responses.
            r_vpipe[0] <= w_acc_rd;
            if (w_acc_rd) begin
                r_dpipe[0] <= w_rd_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
                if (r_vpipe[k-1]) begin
                    r_dpipe[k] <= r_dpipe[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < BE_W; j++) begin
                    r_mem[i][j*8 +: 8] <= 8'(i * 16 + j);
                end
            end
        end else if (w_acc_wr) begin
            for (int j = 0; j < BE_W; j++) begin
                if (byteenable[j]) begin
                    r_mem[w_idx][j*8 +: 8] <= writedata[j*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed bench for avmm_mem_responder: two instances (stalling and zero-wait/long-latency)
// with a scoreboard queue per instance checked against responses as they appear.
module tb_avmm_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] a_addr, b_addr;
    logic        a_read, a_write, b_read, b_write;
    logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [7:0]  a_be, b_be;
    logic        a_rdv, b_rdv, a_wait, b_wait, a_err, b_err;

    avmm_mem_responder #(
        .WAIT_CYCLES(2), .RD_LATENCY(3), .MAX_OUTSTANDING(4)
    ) dut_a (
        .clk(clk), .rst(rst), .address(a_addr), .read(a_read), .write(a_write),
        .writedata(a_wdata), .byteenable(a_be), .readdata(a_rdata),
        .readdatavalid(a_rdv), .waitrequest(a_wait), .err(a_err)
    );

    avmm_mem_responder #(
        .WAIT_CYCLES(0), .RD_LATENCY(6), .MAX_OUTSTANDING(4)
    ) dut_b (
        .clk(clk), .rst(rst), .address(b_addr), .read(b_read), .write(b_write),
        .writedata(b_wdata), .byteenable(b_be), .readdata(b_rdata),
        .readdatavalid(b_rdv), .waitrequest(b_wait), .err(b_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] qa [$];
    logic [63:0] qb [$];
    logic [63:0] em [16];
    int          a_vcnt = 0, b_vcnt = 0, a_errcnt = 0, b_errcnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] init_word(input int i);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(i * 16 + j);
        return w;
    endfunction

    task automatic init_model();
        for (int i = 0; i < 16; i++) em[i] = init_word(i);
    endtask

    // Response monitor: every valid beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rdv) begin
                a_vcnt++;
                if (qa.size() == 0) check("a_spurious_valid", 64'd1, 64'd0);
                else check("a_rdata", a_rdata, qa.pop_front());
            end
            if (b_rdv) begin
                b_vcnt++;
                if (qb.size() == 0) check("b_spurious_valid", 64'd1, 64'd0);
                else check("b_rdata", b_rdata, qb.pop_front());
            end
            if (a_err) a_errcnt++;
            if (b_err) b_errcnt++;
        end
    end

    // Present a command to dut_a and hold it until accepted; returns at the following negedge.
    task automatic a_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [7:0] be, output int edges);
        logic w;
        logic acc;
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
        edges = 0;
        acc = 1'b0;
        while (!acc && edges < 20) begin
            #1;
            w = a_wait;
            @(posedge clk);
            edges++;
            acc = !w;
            @(negedge clk);
        end
        a_read = 1'b0;
        a_write = 1'b0;
        if (!acc) check("a_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic a_rd(input logic [31:0] addr, input logic [63:0] exp);
        int e;
        a_cmd(1'b1, 1'b0, addr, 64'd0, 8'd0, e);
        qa.push_back(exp);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("queue_drain", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    initial begin
        int          edges;
        int          mo;
        int          e0, v0, v1;
        logic        w, v;
        logic [63:0] d;

        rst = 1'b1;
        a_addr = '0; a_read = 0; a_write = 0; a_wdata = '0; a_be = '0;
        b_addr = '0; b_read = 0; b_write = 0; b_wdata = '0; b_be = '0;
        init_model();
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 64'(a_wait), 64'd1);
        check("rst_readdata", a_rdata, 64'd0);
        check("rst_rdvalid", 64'(a_rdv), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("idle_waitrequest", 64'(a_wait), 64'd0);

        // Two stall edges, accept on the third, valid sampled three edges after accept.
        a_cmd(1'b1, 1'b0, 32'd0, 64'd0, 8'd0, edges);
        qa.push_back(64'h0706050403020100);
        check("a_accept_edges", 64'(edges), 64'd3);
        check("a_lat_e1", 64'(a_rdv), 64'd0);
        @(negedge clk);
        check("a_lat_e2", 64'(a_rdv), 64'd0);
        @(negedge clk);
        check("a_lat_e3", 64'(a_rdv), 64'd1);
        @(negedge clk);
        check("a_valid_one_cycle", 64'(a_rdv), 64'd0);
        check("a_rdata_hold", a_rdata, 64'h0706050403020100);

        // Fetch sequence: matrix A rows then vector B.
        v0 = a_vcnt; e0 = a_errcnt;
        for (int i = 0; i < 9; i++) begin
            d = (i == 8) ? 64'h8786858483828180 : em[i];
            a_rd(32'(i), d);
        end
        wait_drain();
        check("fetch_valid_count", 64'(a_vcnt - v0), 64'd9);
        check("fetch_no_err", 64'(a_errcnt - e0), 64'd0);

        // Byte-masked write then read back.
        a_cmd(1'b0, 1'b1, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, edges);
        for (int j = 0; j < 4; j++) em[3][j*8 +: 8] = 8'hFF;
        a_rd(32'd3, 64'h37363534FFFFFFFF);
        wait_drain();

        // Out-of-range read and write, plus read+write collision.
        e0 = a_errcnt;
        a_rd(32'd16, 64'hDEADBEEFDEADBEEF);
        wait_drain();
        check("oor_read_err", 64'(a_errcnt - e0), 64'd1);
        e0 = a_errcnt;
        a_cmd(1'b0, 1'b1, 32'd20, 64'd0, 8'hFF, edges);
        repeat (2) @(negedge clk);
        check("oor_write_err", 64'(a_errcnt - e0), 64'd1);
        a_rd(32'd4, em[4]);
        e0 = a_errcnt;
        a_cmd(1'b1, 1'b1, 32'd5, 64'd0, 8'hFF, edges);
        qa.push_back(em[5]);
        wait_drain();
        check("rw_collision_err", 64'(a_errcnt - e0), 64'd1);
        a_rd(32'd5, em[5]);
        wait_drain();

        // Zero-wait streaming into a 4-deep, 6-cycle pipeline with read held high.
        mo = 0;
        b_read = 1'b1;
        b_addr = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            w = b_wait;
            v = b_rdv;
            check($sformatf("b_wait_model_%0d", k), 64'(w), 64'(mo == 4));
            if (k <= 7) check($sformatf("b_accept_pattern_%0d", k), 64'(!w), 64'(k <= 4));
            @(posedge clk);
            if (!w) qb.push_back(init_word(int'(b_addr)));
            mo = mo + (w ? 0 : 1) - (v ? 1 : 0);
            @(negedge clk);
            if (!w) b_addr = (b_addr + 32'd1) % 32'd8;
        end
        b_read = 1'b0;
        wait_drain();

        // Reset with reads in flight on both instances.
        b_read = 1'b1; b_addr = 32'd1;
        @(negedge clk);
        b_addr = 32'd2;
        @(negedge clk);
        b_read = 1'b0;
        a_cmd(1'b1, 1'b0, 32'd1, 64'd0, 8'd0, edges);
        v0 = a_vcnt; v1 = b_vcnt;
        #2 rst = 1'b1;
        #1;
        check("midrst_a_rdv", 64'(a_rdv), 64'd0);
        check("midrst_b_rdv", 64'(b_rdv), 64'd0);
        check("midrst_b_rdata", b_rdata, 64'd0);
        check("midrst_b_wait", 64'(b_wait), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        init_model();
        repeat (12) @(negedge clk);
        check("postrst_a_no_valid", 64'(a_vcnt - v0), 64'd0);
        check("postrst_b_no_valid", 64'(b_vcnt - v1), 64'd0);
        a_rd(32'd3, 64'h3736353433323130);
        b_read = 1'b1; b_addr = 32'd3;
        @(posedge clk);
        qb.push_back(64'h3736353433323130);
        @(negedge clk);
        b_read = 1'b0;
        wait_drain();
        check("b_no_err", 64'(b_errcnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
